// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer: fetches instructions at PC, strobes the opcode decoder,
// then waits for the datapath (with a watchdog) before advancing or loading the PC.
module control_sequencer #(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               START,
  output logic               IMEM_REQ,
  output logic [PC_W-1:0]    IMEM_ADDR,
  input  logic [INSTR_W-1:0] IMEM_DATA,
  input  logic               IMEM_ACK,
  output logic [3:0]         OPCODE,
  output logic [11:0]        OPERAND,
  output logic               EN_OP,
  output logic               EN_OUT,
  input  logic               EXEC_DONE,
  input  logic               PC_LOAD,
  output logic               BUSY,
  output logic               HALTED,
  output logic               FAULT
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExec, StHalt, StFault
  } state_t;

  state_t             r_state, w_state_next;
  logic [PC_W-1:0]    r_pc, w_pc_next, w_pc_inc;
  logic [INSTR_W-1:0] r_ir, w_ir_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_pc    <= '0;
      r_ir    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_ir    <= w_ir_next;
      r_cnt   <= w_cnt_next;
    end
  end

  assign w_pc_inc = r_pc + PC_W'(1);

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_ir_next    = r_ir;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (START) w_state_next = StFetch;
      end
      StFetch: begin
        if (IMEM_ACK) begin
          w_ir_next    = IMEM_DATA;
          w_state_next = StDecode;
        end
      end
      StDecode: begin
        w_cnt_next = '0;
        case (r_ir[15:12])
          4'h0: begin
            w_pc_next    = w_pc_inc;
            w_state_next = StFetch;
          end
          4'hF: begin
            w_pc_next    = w_pc_inc;
            w_state_next = StHalt;
          end
          4'hD, 4'hE: w_state_next = StFault;
          default:    w_state_next = StExec;
        endcase
      end
      StExec: begin
        // Completion takes priority over a watchdog expiry in the same cycle.
        if (EXEC_DONE) begin
          w_pc_next    = PC_LOAD ? r_ir[PC_W-1:0] : w_pc_inc;
          w_cnt_next   = '0;
          w_state_next = StFetch;
        end else if (r_cnt == CNT_MAX) begin
          w_state_next = StFault;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      StHalt: begin
        if (START) w_state_next = StFetch;
      end
      StFault: w_state_next = StFault;
      default: w_state_next = StIdle;
    endcase
  end

  assign IMEM_REQ  = (r_state == StFetch);
  assign IMEM_ADDR = r_pc;
  assign OPCODE    = r_ir[15:12];
  assign OPERAND   = r_ir[11:0];
  assign EN_OP     = (r_state == StDecode);
  assign EN_OUT    = (r_state == StExec);
  assign BUSY      = (r_state == StFetch) || (r_state == StDecode) || (r_state == StExec);
  assign HALTED    = (r_state == StHalt);
  assign FAULT     = (r_state == StFault);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: a cycle table for the main program flow plus
// hand-written sequences for reset, illegal opcode, watchdog and fetch handshake.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        START, IMEM_ACK, EXEC_DONE, PC_LOAD;
  logic [15:0] IMEM_DATA;
  logic        IMEM_REQ, EN_OP, EN_OUT, BUSY, HALTED, FAULT;
  logic [7:0]  IMEM_ADDR;
  logic [3:0]  OPCODE;
  logic [11:0] OPERAND;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  control_sequencer #(.PC_W(8), .INSTR_W(16), .TIMEOUT(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .START     (START),
    .IMEM_REQ  (IMEM_REQ),
    .IMEM_ADDR (IMEM_ADDR),
    .IMEM_DATA (IMEM_DATA),
    .IMEM_ACK  (IMEM_ACK),
    .OPCODE    (OPCODE),
    .OPERAND   (OPERAND),
    .EN_OP     (EN_OP),
    .EN_OUT    (EN_OUT),
    .EXEC_DONE (EXEC_DONE),
    .PC_LOAD   (PC_LOAD),
    .BUSY      (BUSY),
    .HALTED    (HALTED),
    .FAULT     (FAULT)
  );

  // Packed output view: {req, addr, opcode, operand, en_op, en_out, busy, halted, fault}
  typedef struct packed {
    logic        start;
    logic        ack;
    logic [15:0] data;
    logic        done;
    logic        load;
    logic [29:0] exp;
  } vec_t;

  function automatic logic [29:0] outs();
    return {IMEM_REQ, IMEM_ADDR, OPCODE, OPERAND, EN_OP, EN_OUT, BUSY, HALTED, FAULT};
  endfunction

  function automatic logic [29:0] o(input logic req, input logic [7:0] addr,
                                    input logic [3:0] opc, input logic [11:0] opd,
                                    input logic en_op, input logic en_out, input logic busy,
                                    input logic halted, input logic fault);
    return {req, addr, opc, opd, en_op, en_out, busy, halted, fault};
  endfunction

  function automatic vec_t v(input logic start, input logic ack, input logic [15:0] data,
                             input logic done, input logic load, input logic [29:0] exp);
    vec_t r;
    r.start = start;
    r.ack   = ack;
    r.data  = data;
    r.done  = done;
    r.load  = load;
    r.exp   = exp;
    return r;
  endfunction

  task automatic check(input string name, input logic [29:0] act, input logic [29:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic start, input logic ack, input logic [15:0] data,
                      input logic done, input logic load);
    START     = start;
    IMEM_ACK  = ack;
    IMEM_DATA = data;
    EXEC_DONE = done;
    PC_LOAD   = load;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    START = 0; IMEM_ACK = 0; IMEM_DATA = '0; EXEC_DONE = 0; PC_LOAD = 0;
    rst_n = 1'b0;
    #1;
    check("reset_outputs", outs(), '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  vec_t vecs[22];
  int   n_exec;

  initial begin
    // Straight-line program, halt, resume, jumps, NOP wrap at 0xFF.
    vecs[0]  = v(1, 0, 16'h0000, 0, 0, o(1, 8'h00, 4'h0, 12'h000, 0, 0, 1, 0, 0));
    vecs[1]  = v(0, 1, 16'h1005, 0, 0, o(0, 8'h00, 4'h1, 12'h005, 1, 0, 1, 0, 0));
    vecs[2]  = v(0, 0, 16'h0000, 0, 0, o(0, 8'h00, 4'h1, 12'h005, 0, 1, 1, 0, 0));
    vecs[3]  = v(0, 0, 16'h0000, 1, 0, o(1, 8'h01, 4'h1, 12'h005, 0, 0, 1, 0, 0));
    vecs[4]  = v(0, 1, 16'h2007, 0, 0, o(0, 8'h01, 4'h2, 12'h007, 1, 0, 1, 0, 0));
    vecs[5]  = v(0, 0, 16'h0000, 0, 0, o(0, 8'h01, 4'h2, 12'h007, 0, 1, 1, 0, 0));
    vecs[6]  = v(0, 0, 16'h0000, 1, 0, o(1, 8'h02, 4'h2, 12'h007, 0, 0, 1, 0, 0));
    vecs[7]  = v(0, 1, 16'hF000, 0, 0, o(0, 8'h02, 4'hF, 12'h000, 1, 0, 1, 0, 0));
    vecs[8]  = v(0, 0, 16'h0000, 0, 0, o(0, 8'h03, 4'hF, 12'h000, 0, 0, 0, 1, 0));
    vecs[9]  = v(0, 1, 16'h1234, 1, 1, o(0, 8'h03, 4'hF, 12'h000, 0, 0, 0, 1, 0));
    vecs[10] = v(1, 0, 16'h0000, 0, 0, o(1, 8'h03, 4'hF, 12'h000, 0, 0, 1, 0, 0));
    vecs[11] = v(1, 0, 16'h0000, 0, 0, o(1, 8'h03, 4'hF, 12'h000, 0, 0, 1, 0, 0));
    vecs[12] = v(0, 1, 16'hC0A0, 0, 0, o(0, 8'h03, 4'hC, 12'h0A0, 1, 0, 1, 0, 0));
    vecs[13] = v(0, 0, 16'h0000, 0, 0, o(0, 8'h03, 4'hC, 12'h0A0, 0, 1, 1, 0, 0));
    vecs[14] = v(0, 1, 16'h5555, 1, 1, o(1, 8'hA0, 4'hC, 12'h0A0, 0, 0, 1, 0, 0));
    vecs[15] = v(0, 1, 16'hC0FF, 0, 0, o(0, 8'hA0, 4'hC, 12'h0FF, 1, 0, 1, 0, 0));
    vecs[16] = v(0, 0, 16'h0000, 0, 0, o(0, 8'hA0, 4'hC, 12'h0FF, 0, 1, 1, 0, 0));
    vecs[17] = v(0, 0, 16'h0000, 1, 1, o(1, 8'hFF, 4'hC, 12'h0FF, 0, 0, 1, 0, 0));
    vecs[18] = v(0, 1, 16'h0000, 0, 0, o(0, 8'hFF, 4'h0, 12'h000, 1, 0, 1, 0, 0));
    vecs[19] = v(0, 0, 16'h0000, 0, 0, o(1, 8'h00, 4'h0, 12'h000, 0, 0, 1, 0, 0));
    vecs[20] = v(0, 1, 16'hF000, 0, 0, o(0, 8'h00, 4'hF, 12'h000, 1, 0, 1, 0, 0));
    vecs[21] = v(0, 0, 16'h0000, 0, 0, o(0, 8'h01, 4'hF, 12'h000, 0, 0, 0, 1, 0));

    do_reset();
    for (int i = 0; i < 22; i++) begin
      step(vecs[i].start, vecs[i].ack, vecs[i].data, vecs[i].done, vecs[i].load);
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Reset asserted mid-fetch with PC=1: request must drop without waiting for a clock.
    step(1, 0, 16'h0000, 0, 0);
    check("fetch_before_reset", outs(), o(1, 8'h01, 4'hF, 12'h000, 0, 0, 1, 0, 0));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_mid_fetch", outs(), '0);
    @(posedge clk);
    #1;
    check("reset_held", outs(), '0);
    rst_n = 1'b1;

    // Illegal opcode goes to FAULT without EXEC; START cannot leave it.
    do_reset();
    step(1, 0, 16'h0000, 0, 0);
    step(0, 1, 16'hD123, 0, 0);
    check("illegal_decode", outs(), o(0, 8'h00, 4'hD, 12'h123, 1, 0, 1, 0, 0));
    step(0, 0, 16'h0000, 0, 0);
    check("illegal_fault", outs(), o(0, 8'h00, 4'hD, 12'h123, 0, 0, 0, 0, 1));
    for (int i = 0; i < 4; i++) begin
      step(i[0] == 1'b0, 1, 16'h1111, 1, 1);
      check($sformatf("fault_sticky%0d", i), outs(), o(0, 8'h00, 4'hD, 12'h123, 0, 0, 0, 0, 1));
    end

    // Watchdog expiry: 64 EXEC cycles then FAULT.
    do_reset();
    step(1, 0, 16'h0000, 0, 0);
    step(0, 1, 16'h3042, 0, 0);
    step(0, 0, 16'h0000, 0, 0);
    n_exec = 0;
    for (int i = 0; i < 200; i++) begin
      if (!EN_OUT) break;
      n_exec++;
      step(0, 0, 16'h0000, 0, 0);
    end
    check("watchdog_exec_cycles", 30'(n_exec), 30'd64);
    check("watchdog_fault", outs(), o(0, 8'h00, 4'h3, 12'h042, 0, 0, 0, 0, 1));

    // DONE in the last allowed EXEC cycle beats the watchdog.
    do_reset();
    step(1, 0, 16'h0000, 0, 0);
    step(0, 1, 16'h3042, 0, 0);
    step(0, 0, 16'h0000, 0, 0);
    for (int i = 0; i < 63; i++) step(0, 0, 16'h0000, 0, 0);
    check("exec_cycle63", outs(), o(0, 8'h00, 4'h3, 12'h042, 0, 1, 1, 0, 0));
    step(0, 0, 16'h0000, 1, 0);
    check("done_beats_timeout", outs(), o(1, 8'h01, 4'h3, 12'h042, 0, 0, 1, 0, 0));

    // Spurious ACK/DONE in IDLE, then a slow fetch with bus noise before ACK.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 16'hF0FF, 1, 1);
      check($sformatf("idle_spurious%0d", i), outs(), '0);
    end
    step(1, 0, 16'h0000, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, (i[0] ? 16'hAAAA : 16'h5555), 0, 0);
      check($sformatf("slow_fetch%0d", i), outs(), o(1, 8'h00, 4'h0, 12'h000, 0, 0, 1, 0, 0));
    end
    step(0, 1, 16'h4007, 0, 0);
    check("ack_capture", outs(), o(0, 8'h00, 4'h4, 12'h007, 1, 0, 1, 0, 0));
    step(0, 1, 16'h9999, 0, 0);
    check("ack_outside_fetch", outs(), o(0, 8'h00, 4'h4, 12'h007, 0, 1, 1, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
